// File: rtl/load_wb_select_pkg.sv
// Shared load-size and writeback-state encodings for the MEM/WB boundary.
// Imported by the writeback-select stage and its lane aligner.
package load_wb_select_pkg;

  localparam logic [1:0] LD_BYTE = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_WORD = 2'b10;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_e;

  // Size code 2'b11 behaves as a full word.
  function automatic logic is_word(input logic [1:0] size);
    return (size == LD_WORD) || (size == 2'b11);
  endfunction

endpackage

// File: rtl/load_wb_select_align.sv
// Purely combinational little-endian lane select plus sign/zero extension of a load word.
// Zero latency; no handshake.
module load_align
  import load_wb_select_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        size,
  input  logic              ld_unsigned,
  input  logic [1:0]        addr_lo,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        byte_fill;
  logic        half_fill;

  always_comb begin
    byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];
    byte_fill = ~ld_unsigned & byte_lane[7];
    half_fill = ~ld_unsigned & half_lane[15];
  end

  always_comb begin
    data = rdata;
    if (!is_word(size)) begin
      if (size == LD_BYTE) begin
        data = {{(DATA_W-8){byte_fill}}, byte_lane};
      end else begin
        data = {{(DATA_W-16){half_fill}}, half_lane};
      end
    end
  end

endmodule

// File: rtl/load_wb_select.sv
// Writeback select: ALU results commit one cycle after accept; loads wait for dmem, then align and commit.
// in_ready is low while a load is outstanding; a missing response is abandoned after TIMEOUT_CYC cycles.
module load_wb_select
  import load_wb_select_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mem_to_reg,
  input  logic              in_reg_wen,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [1:0]        in_ld_size,
  input  logic              in_ld_unsigned,
  input  logic [1:0]        in_addr_lo,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_wen,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              load_timeout
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  wb_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [REG_AW-1:0] ld_rd_q, ld_rd_d;
  logic              ld_wen_q, ld_wen_d;
  logic [1:0]        ld_size_q, ld_size_d;
  logic              ld_uns_q, ld_uns_d;
  logic [1:0]        ld_alo_q, ld_alo_d;

  logic              wb_wen_q, wb_wen_d;
  logic [REG_AW-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              timeout_q, timeout_d;

  logic              accept;
  logic [DATA_W-1:0] ld_aligned;

  load_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .rdata       (dmem_rdata),
    .size        (ld_size_q),
    .ld_unsigned (ld_uns_q),
    .addr_lo     (ld_alo_q),
    .data        (ld_aligned)
  );

  assign in_ready = (state_q == WB_IDLE);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld_rd_d   = ld_rd_q;
    ld_wen_d  = ld_wen_q;
    ld_size_d = ld_size_q;
    ld_uns_d  = ld_uns_q;
    ld_alo_d  = ld_alo_q;
    wb_wen_d  = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    timeout_d = timeout_q;

    unique case (state_q)
      WB_IDLE: begin
        // dmem_rvalid is deliberately ignored here: no load is outstanding.
        if (accept) begin
          if (!in_mem_to_reg) begin
            wb_wen_d  = in_reg_wen & (in_rd != '0);
            wb_addr_d = in_rd;
            wb_data_d = in_alu_result;
          end else begin
            ld_rd_d   = in_rd;
            ld_wen_d  = in_reg_wen;
            ld_size_d = in_ld_size;
            ld_uns_d  = in_ld_unsigned;
            ld_alo_d  = in_addr_lo;
            cnt_d     = '0;
            state_d   = WB_WAIT_LOAD;
          end
        end
      end

      WB_WAIT_LOAD: begin
        cnt_d = cnt_q + 1'b1;
        // A response arriving on the final cycle still wins over the timeout.
        if (dmem_rvalid) begin
          wb_wen_d  = ld_wen_q & (ld_rd_q != '0);
          wb_addr_d = ld_rd_q;
          wb_data_d = ld_aligned;
          state_d   = WB_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = WB_IDLE;
        end
      end

      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WB_IDLE;
      cnt_q     <= '0;
      ld_rd_q   <= '0;
      ld_wen_q  <= 1'b0;
      ld_size_q <= LD_WORD;
      ld_uns_q  <= 1'b0;
      ld_alo_q  <= '0;
      wb_wen_q  <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ld_rd_q   <= ld_rd_d;
      ld_wen_q  <= ld_wen_d;
      ld_size_q <= ld_size_d;
      ld_uns_q  <= ld_uns_d;
      ld_alo_q  <= ld_alo_d;
      wb_wen_q  <= wb_wen_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      timeout_q <= timeout_d;
    end
  end

  assign wb_wen       = wb_wen_q;
  assign wb_addr      = wb_addr_q;
  assign wb_data      = wb_data_q;
  assign busy         = (state_q == WB_WAIT_LOAD);
  assign load_timeout = timeout_q;

endmodule

// File: tb/tb_load_wb_select.sv
// Self-checking bench for load_wb_select: directed scenarios followed by random traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_load_wb_select;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_mem_to_reg = 1'b0;
  logic        in_reg_wen = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_alu_result = '0;
  logic [1:0]  in_ld_size = '0;
  logic        in_ld_unsigned = 1'b0;
  logic [1:0]  in_addr_lo = '0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_wen;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        busy;
  logic        load_timeout;

  int n_vec  = 0;
  int n_miss = 0;

  load_wb_select #(.DATA_W(32), .REG_AW(5), .TIMEOUT_CYC(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_mem_to_reg  (in_mem_to_reg),
    .in_reg_wen     (in_reg_wen),
    .in_rd          (in_rd),
    .in_alu_result  (in_alu_result),
    .in_ld_size     (in_ld_size),
    .in_ld_unsigned (in_ld_unsigned),
    .in_addr_lo     (in_addr_lo),
    .dmem_rvalid    (dmem_rvalid),
    .dmem_rdata     (dmem_rdata),
    .wb_wen         (wb_wen),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .busy           (busy),
    .load_timeout   (load_timeout)
  );

  always #5 clk = ~clk;

  // Reference model: one outstanding load and the number of cycles already waited.
  bit          m_pending;
  int          m_waited;
  bit [4:0]    m_rd;
  bit          m_wen;
  bit [1:0]    m_size;
  bit          m_uns;
  bit [1:0]    m_alo;
  bit          e_wen;
  bit [4:0]    e_addr;
  bit [31:0]   e_data;
  bit          e_to;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [31:0] ref_align(bit [31:0] w, bit [1:0] size, bit uns, bit [1:0] alo);
    longint v;
    int     nbytes;
    int     shift;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    shift  = (nbytes == 1) ? 8 * alo : (nbytes == 2) ? 16 * (alo / 2) : 0;
    v = (longint'(w) >> shift) & ((64'sd1 <<< (8 * nbytes)) - 1);
    if (!uns && v >= (64'sd1 <<< (8 * nbytes - 1)))
      v = v - (64'sd1 <<< (8 * nbytes));
    return v[31:0];
  endfunction

  task automatic model_reset();
    m_pending = 0;
    m_waited  = 0;
    e_wen     = 0;
    e_addr    = '0;
    e_data    = '0;
    e_to      = 0;
  endtask

  // Advance the model by one clock using the inputs currently on the DUT pins.
  task automatic model_step();
    e_wen = 0;
    if (!m_pending) begin
      if (in_valid) begin
        if (!in_mem_to_reg) begin
          e_wen  = in_reg_wen && (in_rd != 0);
          e_addr = in_rd;
          e_data = in_alu_result;
        end else begin
          m_pending = 1;
          m_waited  = 0;
          m_rd = in_rd; m_wen = in_reg_wen; m_size = in_ld_size;
          m_uns = in_ld_unsigned; m_alo = in_addr_lo;
        end
      end
    end else begin
      m_waited++;
      if (dmem_rvalid) begin
        e_wen     = m_wen && (m_rd != 0);
        e_addr    = m_rd;
        e_data    = ref_align(dmem_rdata, m_size, m_uns, m_alo);
        m_pending = 0;
      end else if (m_waited == TO) begin
        e_to      = 1;
        m_pending = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("wb_wen",       {31'b0, wb_wen},       {31'b0, e_wen});
    chk("wb_addr",      {27'b0, wb_addr},      {27'b0, e_addr});
    chk("wb_data",      wb_data,               e_data);
    chk("busy",         {31'b0, busy},         {31'b0, m_pending});
    chk("in_ready",     {31'b0, in_ready},     {31'b0, !m_pending});
    chk("load_timeout", {31'b0, load_timeout}, {31'b0, e_to});
  endtask

  // Inputs are applied 1 time unit after a rising edge; outputs checked 1 unit after the next.
  task automatic cyc(input bit v, input bit mtr, input bit wen, input bit [4:0] rd,
                     input bit [31:0] alu, input bit [1:0] size, input bit uns,
                     input bit [1:0] alo, input bit rv, input bit [31:0] rdata);
    in_valid = v; in_mem_to_reg = mtr; in_reg_wen = wen; in_rd = rd;
    in_alu_result = alu; in_ld_size = size; in_ld_unsigned = uns; in_addr_lo = alo;
    dmem_rvalid = rv; dmem_rdata = rdata;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_cyc(input bit rv, input bit [31:0] rdata);
    cyc(0, 0, 0, 5'd0, 32'h0, 2'd0, 0, 2'd0, rv, rdata);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    check_all();
    rst_n = 1'b1;
  endtask

  task automatic load(input bit [4:0] rd, input bit [1:0] size, input bit uns,
                      input bit [1:0] alo, input int gap, input bit [31:0] rdata);
    cyc(1, 1, 1, rd, 32'hDEAD_BEEF, size, uns, alo, 0, 32'h0);
    for (int i = 0; i < gap; i++) idle_cyc(0, 32'h0);
    idle_cyc(1, rdata);
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Back-to-back ALU results.
    cyc(1, 0, 1, 5'd3, 32'h0000_1234, 2'd0, 0, 2'd0, 0, 32'h0);
    chk("alu1_data", wb_data, 32'h0000_1234);
    cyc(1, 0, 1, 5'd4, 32'h0000_ABCD, 2'd0, 0, 2'd0, 0, 32'h0);
    chk("alu2_data", wb_data, 32'h0000_ABCD);
    chk("alu2_wen", {31'b0, wb_wen}, 32'd1);

    // r0 is never written.
    cyc(1, 0, 1, 5'd0, 32'h5555_5555, 2'd0, 0, 2'd0, 0, 32'h0);
    chk("r0_wen", {31'b0, wb_wen}, 32'd0);

    // lb with the response three cycles after accept.
    load(5'd7, 2'd0, 0, 2'd2, 2, 32'h0080_FF00);
    chk("lb_data", wb_data, 32'hFFFF_FF80);

    load(5'd8, 2'd1, 1, 2'd2, 0, 32'h8001_7FFF);
    chk("lhu_data", wb_data, 32'h0000_8001);
    load(5'd8, 2'd1, 0, 2'd2, 0, 32'h8001_7FFF);
    chk("lh_data", wb_data, 32'hFFFF_8001);
    load(5'd8, 2'd2, 0, 2'd2, 0, 32'h8001_7FFF);
    chk("lw_data", wb_data, 32'h8001_7FFF);

    // Abandoned load.
    cyc(1, 1, 1, 5'd9, 32'h0, 2'd2, 0, 2'd0, 0, 32'h0);
    for (int i = 0; i < TO; i++) idle_cyc(0, 32'h0);
    chk("to_flag", {31'b0, load_timeout}, 32'd1);
    chk("to_ready", {31'b0, in_ready}, 32'd1);

    // Response on the final permitted cycle still commits.
    do_reset();
    load(5'd10, 2'd2, 0, 2'd0, TO - 1, 32'hCAFE_F00D);
    chk("last_wen", {31'b0, wb_wen}, 32'd1);
    chk("last_to", {31'b0, load_timeout}, 32'd0);

    // Reset in the middle of a load, then a stray response.
    cyc(1, 1, 1, 5'd11, 32'h0, 2'd2, 0, 2'd0, 0, 32'h0);
    idle_cyc(0, 32'h0);
    do_reset();
    idle_cyc(1, 32'h1234_5678);
    chk("rst_nowrite", {31'b0, wb_wen}, 32'd0);
    idle_cyc(1, 32'h8765_4321);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      bit v;
      bit mtr;
      bit rv;
      v   = ($urandom_range(0, 3) != 0);
      mtr = ($urandom_range(0, 2) == 0);
      rv  = m_pending ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 7) == 0);
      cyc(v, mtr, 1'($urandom), 5'($urandom), $urandom, 2'($urandom),
          1'($urandom), 2'($urandom), rv, $urandom);
      if (n == 1500) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
